// File: rtl/frame_sequencer.sv
// frame_sequencer: walks enabled sub-block tasks (init tasks once, then a repeating frame loop) and arbitrates the shared buses.
module frame_sequencer #(
   parameter int N_TASKS   = 4,
   parameter int LOOP_FROM = 1,
   parameter int TIMEOUT_W = 20
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               go,
   input  logic               pause,
   input  logic [N_TASKS-1:0] enable_mask,
   input  logic [N_TASKS-1:0] task_done,
   output logic [N_TASKS-1:0] task_start,
   output logic [2:0]         owner,
   output logic               owner_valid,
   output logic               busy,
   output logic [15:0]        frame_count,
   output logic               timeout_err
);
   typedef enum logic [2:0] {IDLE, SELECT, START, WAIT, HOLD} state_t;
   localparam logic [2:0] FIRST = 3'(LOOP_FROM);
   localparam logic [2:0] LAST  = 3'(N_TASKS - 1);
   state_t state, next;
   logic [2:0] idx;
   logic [TIMEOUT_W-1:0] wd;
   logic ran;
   logic [N_TASKS-1:0] sel;
   logic sel_en, last, timed_out, task_end, empty, advance;
   always_comb begin
      sel       = N_TASKS'(1) << idx;
      sel_en    = |(enable_mask & sel);
      last      = idx == LAST;
      timed_out = &wd;
      task_end  = |(task_done & sel) || timed_out;
      // ran marks a loop-region start since the last wrap; a pass without one is empty
      empty     = state == SELECT && !sel_en && last && !ran;
      advance   = (state == SELECT && !sel_en && !empty) || (state == WAIT && task_end);
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state       <= IDLE;
         idx         <= 3'd0;
         wd          <= '0;
         ran         <= 1'b0;
         frame_count <= 16'd0;
         timeout_err <= 1'b0;
      end else begin
         state <= next;
         idx   <= (state == IDLE || empty) ? 3'd0 : advance ? (last ? FIRST : idx + 3'd1) : idx;
         ran   <= (state == IDLE || (advance && last)) ? 1'b0 : (state == START && idx >= FIRST) ? 1'b1 : ran;
         wd    <= (state == START) ? '0 : (state == WAIT) ? wd + TIMEOUT_W'(1) : wd;
         if (advance && last) frame_count <= frame_count + 16'd1;
         if (state == WAIT && timed_out) timeout_err <= 1'b1;
      end
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = go ? SELECT : IDLE;
         SELECT:  next = sel_en ? START : empty ? IDLE : SELECT;
         START:   next = WAIT;
         WAIT:    next = task_end ? HOLD : WAIT;
         HOLD:    next = pause ? HOLD : SELECT;
         default: next = IDLE;
      endcase
   end
   always_comb begin
      task_start  = (state == START) ? sel : '0;
      owner_valid = state == WAIT;
      owner       = owner_valid ? idx : 3'd0;
      busy        = state != IDLE;
   end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: table-driven mask scenarios plus hand sequences, start pulses checked against a scoreboard queue.
module tb_frame_sequencer;
   logic clock = 1'b0;
   logic reset, go, pause;
   logic [3:0] enable_mask, task_done, task_start;
   logic [2:0] owner;
   logic owner_valid, busy, timeout_err;
   logic [15:0] frame_count;
   frame_sequencer #(.N_TASKS(4), .LOOP_FROM(1), .TIMEOUT_W(4)) dut (
      .clock(clock), .reset(reset), .go(go), .pause(pause), .enable_mask(enable_mask),
      .task_done(task_done), .task_start(task_start), .owner(owner), .owner_valid(owner_valid),
      .busy(busy), .frame_count(frame_count), .timeout_err(timeout_err)
   );
   always #5 clock = ~clock;
   typedef struct {int idx; int fc; int gap;} exp_t;
   typedef struct packed {
      logic [3:0]  mask;
      logic [3:0]  n;
      logic [31:0] seq;
      logic [31:0] fcs;
      logic [31:0] gaps;
      logic        idle_end;
   } vec_t;
   exp_t q[$];
   vec_t vecs[7];
   int errors = 0, checks = 0;
   int cyc = 0, ref_cyc = 0, last_start = 0;
   int done_delay = 5;
   bit hang_en = 0, spur_en = 0;
   always @(posedge clock) cyc <= cyc + 1;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   function automatic int dig(logic [31:0] s, int n, int k);
      return int'(s[4*(n-1-k) +: 4]);
   endfunction
   // sub-block model: done pulse done_delay cycles after its start
   initial begin
      int cnt, who;
      bit sp;
      cnt = 0; who = 0; sp = 0;
      task_done = '0;
      forever begin
         @(negedge clock);
         task_done = '0;
         if (sp) begin task_done[3] = 1'b1; sp = 0; end
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin task_done[who] = 1'b1; ref_cyc = cyc; end
         end
         if (task_start != 0) begin
            for (int i = 0; i < 4; i++) if (task_start[i]) who = i;
            cnt = (hang_en && who == 1) ? 0 : done_delay;
            sp = spur_en && who == 1;
         end
      end
   end
   initial begin
      exp_t e;
      int id;
      forever begin
         @(negedge clock);
         if (task_start != 0) begin
            id = -1;
            for (int i = 0; i < 4; i++) if (task_start[i]) id = (id == -1) ? i : 99;
            last_start = cyc;
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_start: task_start=%b with nothing expected (cycle %0d)", task_start, cyc);
            end else begin
               e = q.pop_front();
               chk("start_index", id, e.idx);
               chk("start_frame_count", frame_count, e.fc);
               if (e.gap >= 0) chk("start_latency", cyc - ref_cyc, e.gap);
            end
         end
      end
   end
   task automatic wait_q(int budget);
      int t = 0;
      while (q.size() != 0 && t < budget) begin @(negedge clock); t++; end
      if (q.size() != 0) begin
         checks++; errors++;
         $display("FAIL start_timeout: %0d expected starts never seen", q.size());
         q.delete();
      end
   endtask
   task automatic pulse_go();
      ref_cyc = cyc;
      go = 1'b1;
      @(negedge clock);
      go = 1'b0;
   endtask
   task automatic push(int i, int f, int g);
      q.push_back('{i, f, g});
   endtask
   task automatic finish_run(int last_idx);
      repeat (2) @(negedge clock);
      chk("owner_mid_wait", owner, last_idx);
      chk("owner_valid_mid_wait", owner_valid, 1);
      #2 reset = 1'b0;
      #1 chk("async_reset_outputs", {task_start, owner, owner_valid, busy, frame_count, timeout_err}, 0);
      @(negedge clock);
      reset = 1'b1;
      repeat (10) @(negedge clock);
      chk("idle_after_abort", busy, 0);
   endtask
   initial begin
      vecs[0] = '{4'hF, 4'd7, 32'h0123123, 32'h0000111, 32'h2333333, 1'b0};
      vecs[1] = '{4'hB, 4'd5, 32'h01313,   32'h00011,   32'h23434,   1'b0};
      vecs[2] = '{4'h5, 4'd4, 32'h0222,    32'h0012,    32'h2455,    1'b0};
      vecs[3] = '{4'h8, 4'd3, 32'h333,     32'h012,     32'h555,     1'b0};
      vecs[4] = '{4'hE, 4'd4, 32'h1231,    32'h0001,    32'h3333,    1'b0};
      vecs[5] = '{4'h1, 4'd1, 32'h0,       32'h0,       32'h2,       1'b1};
      vecs[6] = '{4'h0, 4'd0, 32'h0,       32'h0,       32'h0,       1'b1};
      reset = 1'b0; go = 1'b0; pause = 1'b0; enable_mask = '0;
      repeat (2) @(negedge clock);
      chk("reset_outputs", {task_start, owner, owner_valid, busy, frame_count, timeout_err}, 0);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      chk("idle_after_reset", busy, 0);
      for (int v = 0; v < 7; v++) begin
         vec_t t;
         t = vecs[v];
         for (int k = 0; k < int'(t.n); k++)
            push(dig(t.seq, t.n, k), dig(t.fcs, t.n, k), dig(t.gaps, t.n, k));
         enable_mask = t.mask;
         pulse_go();
         wait_q(300);
         if (t.idle_end) begin
            repeat (20) @(negedge clock);
            chk("empty_pass_idle", busy, 0);
            chk("empty_pass_frames", frame_count, 0);
            reset = 1'b0;
            @(negedge clock);
            reset = 1'b1;
            repeat (3) @(negedge clock);
         end else finish_run(dig(t.seq, t.n, t.n - 1));
      end
      // pause holds between tasks, then task 3 starts two cycles after release
      enable_mask = 4'hF;
      push(0, 0, 2); push(1, 0, 3); push(2, 0, 3);
      pulse_go();
      wait_q(200);
      pause = 1'b1;
      repeat (10) @(negedge clock);
      chk("pause_busy", busy, 1);
      chk("pause_owner_valid", owner_valid, 0);
      chk("pause_owner", owner, 0);
      push(3, 0, 2);
      ref_cyc = cyc;
      pause = 1'b0;
      wait_q(20);
      finish_run(3);
      // a foreign task_done while task 1 owns is ignored
      spur_en = 1;
      push(0, 0, 2); push(1, 0, 3);
      pulse_go();
      wait_q(200);
      repeat (2) @(negedge clock);
      chk("spurious_owner", owner, 1);
      chk("spurious_owner_valid", owner_valid, 1);
      push(2, 0, 3);
      wait_q(50);
      spur_en = 0;
      finish_run(2);
      // watchdog: task 1 never completes
      hang_en = 1;
      push(0, 0, 2); push(1, 0, 3);
      pulse_go();
      wait_q(200);
      while (cyc < last_start + 14) @(negedge clock);
      chk("timeout_not_yet", timeout_err, 0);
      chk("timeout_owner", owner, 1);
      push(2, 0, -1);
      wait_q(40);
      chk("timeout_set", timeout_err, 1);
      hang_en = 0;
      push(3, 0, 3); push(1, 1, 3); push(2, 1, 3);
      wait_q(200);
      chk("timeout_sticky", timeout_err, 1);
      finish_run(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter N_TASKS, default 4, number of sub-block tasks sequenced (legal 2..8).
REQ-002 Parameter LOOP_FROM, default 1, first task index of the repeating frame loop; tasks 0..LOOP_FROM-1 are init-only (legal 0..N_TASKS-1).
REQ-003 Parameter TIMEOUT_W, default 20, width of per-task watchdog counter.
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; asserted (0) forces reset state immediately, independent of clock.
REQ-006 go  input  1  one-cycle pulse; starts the sequence from task 0 when idle.
REQ-007 pause  input  1  level; holds the sequencer between tasks while high.
REQ-008 enable_mask  input  N_TASKS  per-task enable; 0 = task skipped.
REQ-009 task_done  input  N_TASKS  per-task completion pulse from sub-blocks.
REQ-010 task_start  output  N_TASKS  one-hot one-cycle start pulse to the selected task.
REQ-011 owner  output  3  index of task granted shared grid/VGA buses.
REQ-012 owner_valid  output  1  high while owner holds the buses.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 frame_count  output  16  number of completed loop passes.
REQ-015 timeout_err  output  1  sticky; set when any task exceeds the watchdog.

Function
REQ-016 States SHALL be IDLE, SELECT, START, WAIT, HOLD; encoding free.
REQ-017 IDLE: on go=1, idx <= 0, go to SELECT; go ignored in all other states.
REQ-018 SELECT (one cycle per examined index): if enable_mask[idx]=1 go to START, else advance idx per REQ-021 and stay in SELECT.
REQ-019 START (exactly one cycle): task_start[idx]=1, all other bits 0; clear watchdog; next WAIT.
REQ-020 WAIT: owner=idx, owner_valid=1; on task_done[idx]=1 or watchdog all-ones, go to HOLD and advance idx; task_done bits for other indices ignored; task_done in START cycle ignored.
REQ-021 Index advance: idx+1 if idx<N_TASKS-1; else idx <= LOOP_FROM and frame_count increments by 1 (wraps 16'hFFFF -> 0).
REQ-022 HOLD: if pause=1 remain; else go to SELECT; pause has no effect in any other state (a running task is never interrupted).
REQ-023 Watchdog increments by 1 each WAIT cycle; reaching all-ones sets timeout_err=1 and ends the task as if done.
REQ-024 enable_mask SHALL be sampled only in SELECT; changes during WAIT do not affect the running task.
REQ-025 If SELECT examines all indices LOOP_FROM..N_TASKS-1 disabled in one pass after init (no START since last wrap), go to IDLE; frame_count not incremented for the empty pass.
REQ-026 Outside WAIT: owner=0, owner_valid=0, task_start=0 except in START.
REQ-027 Latency: go to first task_start (task 0 enabled) SHALL be 2 cycles; task_done to next enabled task_start SHALL be 3 cycles (HOLD, SELECT, START) with pause=0.

Reset
REQ-028 While reset=0: state IDLE, idx=0, watchdog=0, task_start=0, owner=0, owner_valid=0, busy=0, frame_count=0, timeout_err=0.
REQ-029 Reset asserted mid-task SHALL abort with no further start pulse; the sub-block's later task_done is ignored (IDLE).
REQ-030 After reset release, the sequencer SHALL remain IDLE until go.

Verification
REQ-031 N_TASKS=4, LOOP_FROM=1, mask=4'hF, go, each task done 5 cycles after start -> start order 0,1,2,3,1,2,3...; frame_count=1 after task 3's first done; task 0 never restarted.
REQ-032 mask=4'b1011 -> task 2 never started; owner sequence 0,1,3,1,3; done-to-start gap 3 cycles on 1->3 plus 1 skip cycle.
REQ-033 TIMEOUT_W=4, task 1 never done -> after 15 WAIT cycles timeout_err=1, task 2 starts; timeout_err stays 1 through subsequent frames.
REQ-034 pause=1 during task 2 WAIT, done arrives -> sequencer in HOLD, owner_valid=0, no task_start until pause=0, then task 3 starts 2 cycles later.
REQ-035 task_done[3] pulsed while task 1 owns -> ignored; reset=0 asynchronously mid-WAIT -> all outputs 0 before the next clock edge.
REQ-036 mask=4'b0001 -> task 0 runs once, then IDLE, busy=0, frame_count=0.
